mips8_sequencer: RTL and testbench
==================================

MIPS8_SEQUENCER -- requirements
Module: mips8_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum MEM-state cycles waited for mem_ready before a fault is raised; legal range 1..255.
REQ-002 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-low reset (0 = reset), sampled on the rising clk edge.
REQ-004 Port start, input, 1: launches execution from IDLE or HALT.
REQ-005 Port instr, input, 8: instruction-memory read data, valid one cycle after imem_ren.
REQ-006 Port zero, input, 1: ALU status zero flag, sampled in EXEC.
REQ-007 Port mem_ready, input, 1: data-memory completion handshake.
REQ-008 Port pc, output, 8: program counter, driven to instruction memory.
REQ-009 Port imem_ren, output, 1: instruction fetch strobe.
REQ-010 Port ir, output, 8: latched instruction register.
REQ-011 Port alu_op, output, 3: ALU operation, equal to ir[7:5].
REQ-012 Port alu_en, output, 1: ALU evaluate strobe.
REQ-013 Port rf_addr1 and rf_addr2, output, 2 each: register-file read addresses (ir[4:3] and ir[2:1]).
REQ-014 Port rf_ren and rf_wen, output, 1 each: register-file read and write strobes.
REQ-015 Port mem_ren and mem_wen, output, 1 each: data-memory read and write strobes.
REQ-016 Port mem_addr, output, 8: data-memory address, {5'b0, ir[2:0]}.
REQ-017 Port busy, halted and fault, output, 1 each: status flags.
REQ-018 Port state, output, 3: current FSM state encoding.

Function
REQ-019 Opcodes in ir[7:5] SHALL decode as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LD, 101 ST, 110 BEQZ, 111 JMP; instr 8'hFF SHALL be HALT.
REQ-020 FSM states SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 is unreachable and SHALL recover to IDLE on the next edge.
REQ-021 IDLE: when start=1, go to FETCH with pc<=0; otherwise stay.
REQ-022 FETCH: imem_ren=1 for exactly one cycle, then go to DECODE.
REQ-023 DECODE: ir<=instr and rf_ren=1; if instr==8'hFF go to HALT, else go to EXEC.
REQ-024 EXEC, ALU opcodes: alu_en=1 for one cycle, then go to WB.
REQ-025 EXEC, LD/ST: go to MEM and clear the timeout counter.
REQ-026 EXEC, BEQZ: if zero=1, pc<=pc+{{5{ir[2]}},ir[2:0]} (signed offset, modulo 256); else pc<=pc+1; then go to FETCH.
REQ-027 EXEC, JMP: pc<={3'b000, ir[4:0]}, then go to FETCH.
REQ-028 MEM: hold mem_ren (LD) or mem_wen (ST) high continuously until mem_ready=1; the strobe SHALL NOT deassert early.
REQ-029 MEM on mem_ready=1: LD goes to WB; ST sets pc<=pc+1 and goes to FETCH.
REQ-030 MEM timeout: if MEM_TIMEOUT cycles elapse with mem_ready=0, set fault<=1, drop the strobes and go to HALT.
REQ-031 WB: rf_wen=1 for one cycle, pc<=pc+1, then go to FETCH.
REQ-032 pc arithmetic SHALL be 8-bit modulo; 8'hFF+1 wraps to 8'h00.
REQ-033 HALT: halted=1; when start=1, clear fault, set pc<=0 and go to FETCH.
REQ-034 start SHALL be ignored in every state except IDLE and HALT.
REQ-035 busy SHALL be 1 in every state except IDLE and HALT.
REQ-036 All strobes (imem_ren, alu_en, rf_ren, rf_wen, mem_ren, mem_wen) SHALL be registered Moore outputs that are mutually exclusive in time, except rf_ren with DECODE-state decode.
REQ-037 Cycle counts SHALL be: ALU instruction 4 cycles; BEQZ and JMP 3 cycles; ST 3+N cycles; LD 4+N cycles, where N is the number of MEM cycles including the mem_ready cycle.

Reset
REQ-038 When reset=0 at a clock edge: state<=IDLE, pc<=0, ir<=0, fault<=0, timeout counter<=0, and all strobes, busy and halted <=0.
REQ-039 Reset SHALL take priority over start and mem_ready in every state, including mid-MEM, where it drops strobes on that edge.

Verification
REQ-040 Reset, start, ADD (instr 8'h0A): FETCH, DECODE, EXEC with alu_en=1 and alu_op=0, WB with rf_wen=1; pc goes 0→1 after 4 cycles.
REQ-041 BEQZ 8'hC7 at pc=8'h05: zero=1 gives pc=8'h04, zero=0 gives pc=8'h06; pc=8'hFF with zero=0 gives pc=8'h00.
REQ-042 LD 8'h8D with mem_ready delayed 3 cycles: mem_ren is high for 3 cycles, mem_addr=8'h05, then WB with rf_wen=1.
REQ-043 ST with mem_ready held at 0 (MEM_TIMEOUT=16): after 16 MEM cycles fault=1, halted=1, mem_wen=0; a later start clears fault and sets pc=0.
REQ-044 Instr 8'hFF in DECODE goes to HALT with busy=0; a start pulse during EXEC is ignored.
REQ-045 reset=0 asserted during MEM with mem_ren=1 gives state=IDLE and mem_ren=0 on the next edge.

Source files
------------

// File: rtl/mips8_sequencer.sv
// Multi-cycle control sequencer for an 8-bit MIPS-like datapath.
// Every strobe is a registered Moore output, decoded from the next state.
module mips8_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [7:0] pc,
  output logic       imem_ren,
  output logic [7:0] ir,
  output logic [2:0] alu_op,
  output logic       alu_en,
  output logic [1:0] rf_addr1,
  output logic [1:0] rf_addr2,
  output logic       rf_ren,
  output logic       rf_wen,
  output logic       mem_ren,
  output logic       mem_wen,
  output logic [7:0] mem_addr,
  output logic       busy,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;
  localparam logic [7:0] INSTR_HALT   = 8'hFF;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       fault_q, fault_d;
  logic [7:0] tmo_q, tmo_d;
  logic       imem_ren_q, imem_ren_d;
  logic       alu_en_q, alu_en_d;
  logic       rf_ren_q, rf_ren_d;
  logic       rf_wen_q, rf_wen_d;
  logic       mem_ren_q, mem_ren_d;
  logic       mem_wen_q, mem_wen_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;

  logic [2:0] opcode;
  logic [7:0] branch_off;
  logic [7:0] pc_inc;

  assign opcode     = ir_q[7:5];
  assign branch_off = {{5{ir_q[2]}}, ir_q[2:0]};
  assign pc_inc     = pc_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = 8'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = instr;
        state_d = (instr == INSTR_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_ST: begin
            tmo_d   = 8'd0;
            state_d = S_MEM;
          end
          OP_BEQZ: begin
            pc_d    = zero ? (pc_q + branch_off) : pc_inc;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = {3'b000, ir_q[4:0]};
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LD) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end else if (tmo_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          fault_d = 1'b0;
          pc_d    = 8'd0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes follow the state being entered, so each one is high for exactly its state's cycles.
  always_comb begin
    imem_ren_d = (state_d == S_FETCH);
    rf_ren_d   = (state_d == S_DECODE);
    alu_en_d   = (state_d == S_EXEC) && (ir_d[7] == 1'b0);
    rf_wen_d   = (state_d == S_WB);
    mem_ren_d  = (state_d == S_MEM) && (ir_d[7:5] == OP_LD);
    mem_wen_d  = (state_d == S_MEM) && (ir_d[7:5] == OP_ST);
    busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= 8'd0;
      ir_q       <= 8'd0;
      fault_q    <= 1'b0;
      tmo_q      <= 8'd0;
      imem_ren_q <= 1'b0;
      alu_en_q   <= 1'b0;
      rf_ren_q   <= 1'b0;
      rf_wen_q   <= 1'b0;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      fault_q    <= fault_d;
      tmo_q      <= tmo_d;
      imem_ren_q <= imem_ren_d;
      alu_en_q   <= alu_en_d;
      rf_ren_q   <= rf_ren_d;
      rf_wen_q   <= rf_wen_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign alu_op   = ir_q[7:5];
  assign rf_addr1 = ir_q[4:3];
  assign rf_addr2 = ir_q[2:1];
  assign mem_addr = {5'b00000, ir_q[2:0]};
  assign imem_ren = imem_ren_q;
  assign alu_en   = alu_en_q;
  assign rf_ren   = rf_ren_q;
  assign rf_wen   = rf_wen_q;
  assign mem_ren  = mem_ren_q;
  assign mem_wen  = mem_wen_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign fault    = fault_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mips8_sequencer.sv
// Self-checking bench: each instruction is run against an instruction-level
// model giving cycle count, next pc, strobe counts and halt/fault outcome.
module tb_mips8_sequencer;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] instr = 8'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [7:0] pc, ir, mem_addr;
  logic [2:0] alu_op, state;
  logic [1:0] rf_addr1, rf_addr2;
  logic       imem_ren, alu_en, rf_ren, rf_wen, mem_ren, mem_wen;
  logic       busy, halted, fault;

  logic [7:0] imem [256];
  logic [7:0] exp_pc;
  logic       exp_fault;
  int         vectors = 0;
  int         miscompares = 0;

  mips8_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .zero(zero),
    .mem_ready(mem_ready), .pc(pc), .imem_ren(imem_ren), .ir(ir),
    .alu_op(alu_op), .alu_en(alu_en), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_ren(rf_ren), .rf_wen(rf_wen), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .busy(busy), .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) instr <= imem[pc];

  // Runs one instruction; entered and left at a negedge with the DUT in FETCH.
  task automatic exec_one(input logic [7:0] op, input int zmode, input int d);
    logic [7:0] npc;
    logic       z, ehalt, efault, done;
    int ecyc, emr, emw, ealu, erfw, erfr, off;
    int cycles, mc, n_alu, n_rfr, n_rfw, n_mr, n_mw, excl_bad, busy_bad, field_bad;
    z = (zmode == 2) ? 1'($urandom % 2) : 1'(zmode);
    ehalt = 1'b0; efault = 1'b0; ealu = 0; erfw = 0; erfr = 1; emr = 0; emw = 0;
    npc = exp_pc;
    if (op == 8'hFF) begin
      ecyc = 2; ehalt = 1'b1;
    end else begin
      case (op[7:5])
        3'd4, 3'd5: begin
          if (d == 0) begin
            ecyc = 3 + TMO; ehalt = 1'b1; efault = 1'b1;
            if (op[7:5] == 3'd4) emr = TMO; else emw = TMO;
          end else begin
            npc = 8'(exp_pc + 8'd1);
            if (op[7:5] == 3'd4) begin ecyc = 4 + d; emr = d; erfw = 1; end
            else begin ecyc = 3 + d; emw = d; end
          end
        end
        3'd6: begin
          ecyc = 3;
          off = op[2] ? int'(op[2:0]) - 8 : int'(op[2:0]);
          npc = z ? 8'((int'(exp_pc) + off + 256) % 256) : 8'(exp_pc + 8'd1);
        end
        3'd7: begin ecyc = 3; npc = {3'b000, op[4:0]}; end
        default: begin ecyc = 4; ealu = 1; erfw = 1; npc = 8'(exp_pc + 8'd1); end
      endcase
    end

    vectors++;
    if (imem_ren !== 1'b1 || pc !== exp_pc) begin
      miscompares++;
      $display("FAIL fetch_pc: imem_ren=%b pc=%02h, expected imem_ren=1 pc=%02h", imem_ren, pc, exp_pc);
    end
    imem[exp_pc] = op;
    zero = z;
    cycles = 1; mc = 0; n_alu = 0; n_rfr = 0; n_rfw = 0; n_mr = 0; n_mw = 0;
    excl_bad = 0; busy_bad = 0; field_bad = 0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      start = 1'($urandom % 2);
      @(posedge clk); @(negedge clk);
      if (imem_ren || halted) begin
        done = 1'b1;
      end else begin
        cycles++;
        n_alu += int'(alu_en); n_rfr += int'(rf_ren); n_rfw += int'(rf_wen);
        n_mr += int'(mem_ren); n_mw += int'(mem_wen);
        if ($countones({imem_ren, alu_en, rf_ren, rf_wen, mem_ren, mem_wen}) > 1) excl_bad++;
        if (busy !== 1'b1) busy_bad++;
        if (alu_en && alu_op !== op[7:5]) field_bad++;
        if ((mem_ren || mem_wen) && mem_addr !== {5'b00000, op[2:0]}) field_bad++;
        if (mem_ren || mem_wen) begin
          mc++;
          mem_ready = (mc == d);
        end else begin
          mem_ready = 1'b0;
        end
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;

    vectors++;
    if (!done || cycles != ecyc || halted !== ehalt || fault !== efault) begin
      miscompares++;
      $display("FAIL timing_%02h: done=%b cycles=%0d halted=%b fault=%b, expected cycles=%0d halted=%b fault=%b",
               op, done, cycles, halted, fault, ecyc, ehalt, efault);
    end
    vectors++;
    if (n_alu != ealu || n_rfr != erfr || n_rfw != erfw || n_mr != emr || n_mw != emw) begin
      miscompares++;
      $display("FAIL strobes_%02h: alu=%0d rf_ren=%0d rf_wen=%0d mem_ren=%0d mem_wen=%0d, expected %0d %0d %0d %0d %0d",
               op, n_alu, n_rfr, n_rfw, n_mr, n_mw, ealu, erfr, erfw, emr, emw);
    end
    vectors++;
    if (excl_bad != 0 || busy_bad != 0 || field_bad != 0 || ir !== op) begin
      miscompares++;
      $display("FAIL fields_%02h: overlap=%0d busy_low=%0d bad_fields=%0d ir=%02h, expected 0 0 0 ir=%02h",
               op, excl_bad, busy_bad, field_bad, ir, op);
    end
    vectors++;
    if (ehalt) begin
      if (state !== 3'd6 || busy !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_state_%02h: state=%0d busy=%b mem_ren=%b mem_wen=%b, expected 6 0 0 0",
                 op, state, busy, mem_ren, mem_wen);
      end
    end else if (pc !== npc || state !== 3'd1) begin
      miscompares++;
      $display("FAIL next_pc_%02h: pc=%02h state=%0d, expected pc=%02h state=1", op, pc, state, npc);
    end
    $display("instr %02h at pc %02h zero=%b mem_delay=%0d: %0d cycles, next pc %02h%s",
             op, exp_pc, z, d, cycles, npc, ehalt ? " (halted)" : "");
    exp_pc = npc;
    exp_fault = efault;
  endtask

  // From IDLE or HALT: pulse start and expect FETCH at pc 0 with fault cleared.
  task automatic restart();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    vectors++;
    if (state !== 3'd1 || imem_ren !== 1'b1 || pc !== 8'd0 || fault !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: state=%0d imem_ren=%b pc=%02h fault=%b busy=%b, expected 1 1 00 0 1",
               state, imem_ren, pc, fault, busy);
    end
    exp_pc = 8'd0;
    exp_fault = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    vectors++;
    if (state !== 3'd0 || pc !== 8'd0 || ir !== 8'd0 || fault !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
        {imem_ren, alu_en, rf_ren, rf_wen, mem_ren, mem_wen} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_state: state=%0d pc=%02h ir=%02h fault=%b busy=%b halted=%b, expected all zero",
               state, pc, ir, fault, busy, halted);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: state=%0d busy=%b, expected state=0 busy=0", state, busy);
    end
    restart();
  endtask

  task automatic test_add();
    exec_one(8'h0A, 2, 1);
  endtask

  task automatic test_beqz();
    exec_one(8'hE5, 2, 1);
    exec_one(8'hC7, 1, 1);
    exec_one(8'hE5, 2, 1);
    exec_one(8'hC7, 0, 1);
    exec_one(8'hE0, 2, 1);
    exec_one(8'hC7, 1, 1);
    exec_one(8'hC7, 0, 1);
  endtask

  task automatic test_ld();
    exec_one(8'h8D, 2, 3);
    exec_one(8'hA6, 2, 2);
  endtask

  task automatic test_timeout();
    exec_one(8'hA3, 2, 0);
    restart();
  endtask

  task automatic test_halt();
    exec_one(8'hFF, 2, 1);
    restart();
  endtask

  task automatic test_mem_reset();
    int k;
    imem[exp_pc] = 8'h8D;
    mem_ready = 1'b0;
    k = 0;
    while (mem_ren !== 1'b1 && k < 10) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (mem_ren !== 1'b1 || state !== 3'd4) begin
      miscompares++;
      $display("FAIL mem_entry: mem_ren=%b state=%0d, expected mem_ren=1 state=4", mem_ren, state);
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (state !== 3'd0 || mem_ren !== 1'b0 || pc !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_mem_reset: state=%0d mem_ren=%b pc=%02h busy=%b, expected 0 0 00 0",
               state, mem_ren, pc, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    restart();
  endtask

  task automatic test_random();
    logic [7:0] op;
    int d;
    for (int n = 0; n < 80; n++) begin
      op = 8'($urandom);
      if ($urandom % 16 == 0) op = 8'hFF;
      d = ($urandom % 8 == 0) ? 0 : 1 + int'($urandom % 5);
      exec_one(op, 2, d);
      if (halted) restart();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'd0;
    exp_pc = 8'd0;
    exp_fault = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_beqz();
    test_ld();
    test_timeout();
    test_halt();
    test_mem_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
